txframer: RTL and testbench

Parametrised UART transmit framer: accepts parallel words over a valid/ready handshake and serialises them onto a single line. Each frame is start bit, DATA_W data bits LSB first, an optional parity bit, then STOP_BITS stop bits. It supersedes the fixed 8-bit parity generator: it adds configurable width, mark parity, internal bit timing, a one-word holding buffer for gap-free back-to-back frames, and an optional break generator. It sits between the host-side data source and the TX pin.

---
 rtl/txframer_pkg.sv | 40 ++++
 rtl/txframer_bitclk.sv | 35 +++
 rtl/txframer.sv | 198 +++++++++++++++++++
 tb/tb_txframer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/txframer_pkg.sv
// txframer shared definitions: parity modes, FSM states, parity helper.
// Included by every txframer source via import txframer_pkg::*.
package txframer_pkg;

  localparam int MAX_W = 9;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  typedef struct packed {
    logic [MAX_W-1:0] data;
    logic [1:0]       mode;
  } hold_t;

  // Data is zero-extended to MAX_W; extra zeros leave the XOR unchanged.
  function automatic logic parity_bit(
    input logic [MAX_W-1:0] data,
    input logic [1:0]       mode
  );
    logic p;
    p = ^data;
    case (mode)
      PAR_EVEN: return p;
      PAR_ODD:  return ~p;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/txframer_bitclk.sv
// txbitclk: bit-period timer for the UART transmit framer.
// bit_end marks the last cycle of a bit, pre_end the cycle before it.
module txbitclk
  import txframer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_Pclk,
  input  logic i_Rst,
  input  logic restart,
  output logic bit_end,
  output logic pre_end
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  // Count 0..CLKS_PER_BIT-1, held at zero while restart is high.
  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_end = !restart && (cnt == LAST);
  assign pre_end = !restart && (cnt == PRE);

endmodule

// File: rtl/txframer.sv
// txframer: UART transmit framer with one-word holding buffer.
// Optional break generator enabled by defining TXFRAMER_BREAK_EN.
module txframer
  import txframer_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              i_Pclk,
  input  logic              i_Rst,
  input  logic              i_Valid,
  input  logic [DATA_W-1:0] i_Data,
  input  logic [1:0]        i_Parity,
`ifdef TXFRAMER_BREAK_EN
  input  logic              i_Break,
`endif
  output logic              o_Ready,
  output logic              o_Tx,
  output logic              o_Busy,
  output logic              o_Done
);

  localparam int IW = $clog2(DATA_W);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("txframer: STOP_BITS must be 1 or 2");
  end
  if (DATA_W < 5 || DATA_W > MAX_W) begin : g_bad_width
    $error("txframer: DATA_W must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("txframer: CLKS_PER_BIT must be >= 2");
  end

  state_t            state;
  logic              buf_full;
  logic [DATA_W-1:0] buf_data;
  logic [1:0]        buf_mode;
  logic [DATA_W-1:0] shreg;
  logic [1:0]        mode_q;
  logic              par_q;
  logic [IW-1:0]     bit_idx;
  logic              stop_idx;
  logic              mark_wait;
  logic              brk_q;
  logic              brk_in;
  logic              bit_end;
  logic              pre_end;
  logic              restart;
  logic              last_data;
  logic              last_stop;
  logic              idle_go;
  logic              stop_end;
  logic              load;
  logic              accept;

`ifdef TXFRAMER_BREAK_EN
  assign brk_in = i_Break;
`else
  assign brk_in = 1'b0;
`endif

  assign last_data = (bit_idx == IW'(DATA_W - 1));
  assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
  assign idle_go   = (state == ST_IDLE) && !brk_in && !mark_wait;
  assign stop_end  = (state == ST_STOP) && bit_end && last_stop;
  assign load      = buf_full && (idle_go || stop_end);
  assign restart   = (state == ST_IDLE) && (brk_in || !mark_wait);
  assign o_Ready   = !buf_full && !brk_q;
  assign accept    = i_Valid && o_Ready;

  txbitclk #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bitclk (
    .i_Pclk (i_Pclk),
    .i_Rst  (i_Rst),
    .restart(restart),
    .bit_end(bit_end),
    .pre_end(pre_end)
  );

  // Holding buffer: fill on handshake, drain when the FSM loads it.
  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) begin
      buf_full <= 1'b0;
      buf_data <= '0;
      buf_mode <= PAR_NONE;
    end else if (accept) begin
      buf_full <= 1'b1;
      buf_data <= i_Data;
      buf_mode <= i_Parity;
    end else if (load) begin
      buf_full <= 1'b0;
    end
  end

  // Break seen in IDLE blocks new words until it is released.
  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) begin
      brk_q <= 1'b0;
    end else begin
      brk_q <= (state == ST_IDLE) && brk_in;
    end
  end

  // Frame FSM; o_Tx, o_Busy and o_Done are driven from here.
  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) begin
      state     <= ST_IDLE;
      o_Tx      <= 1'b1;
      o_Busy    <= 1'b0;
      o_Done    <= 1'b0;
      shreg     <= '0;
      mode_q    <= PAR_NONE;
      par_q     <= 1'b0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      mark_wait <= 1'b0;
    end else begin
      o_Done <= (state == ST_STOP) && last_stop && pre_end;
      if (load) begin
        shreg  <= buf_data;
        mode_q <= buf_mode;
        par_q  <= parity_bit(MAX_W'(buf_data), buf_mode);
      end
      case (state)
        ST_IDLE: begin
          if (brk_in) begin
            mark_wait <= 1'b1;
            o_Tx      <= 1'b0;
          end else if (mark_wait) begin
            o_Tx <= 1'b1;
            if (bit_end) begin
              mark_wait <= 1'b0;
            end
          end else if (buf_full) begin
            state  <= ST_START;
            o_Busy <= 1'b1;
            o_Tx   <= 1'b0;
          end else begin
            o_Tx <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            o_Tx    <= shreg[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (!last_data) begin
              bit_idx <= bit_idx + IW'(1);
              shreg   <= {1'b0, shreg[DATA_W-1:1]};
              o_Tx    <= shreg[1];
            end else if (mode_q == PAR_NONE) begin
              state    <= ST_STOP;
              stop_idx <= 1'b0;
              o_Tx     <= 1'b1;
            end else begin
              state <= ST_PARITY;
              o_Tx  <= par_q;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state    <= ST_STOP;
            stop_idx <= 1'b0;
            o_Tx     <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (!last_stop) begin
              stop_idx <= stop_idx + 1'b1;
            end else if (buf_full) begin
              state <= ST_START;
              o_Tx  <= 1'b0;
            end else begin
              state  <= ST_IDLE;
              o_Busy <= 1'b0;
              o_Tx   <= 1'b1;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_Busy <= 1'b0;
          o_Tx   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_txframer.sv
// tb_txframer: table vectors, multi-cycle sequences and random frames
// checked against a bit-level frame model of the UART format.
module tb_txframer;
  import txframer_pkg::*;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int SB  = 1;

  logic       i_Pclk = 1'b0;
  logic       i_Rst;
  logic       i_Valid;
  logic [7:0] i_Data;
  logic [1:0] i_Parity;
`ifdef TXFRAMER_BREAK_EN
  logic       i_Break;
`endif
  logic       o_Ready;
  logic       o_Tx;
  logic       o_Busy;
  logic       o_Done;

  int tests = 0;
  int fails = 0;
  int nbusy;
  logic samp [0:511];

  typedef struct {
    logic [7:0] d;
    logic [1:0] m;
    logic       par;
    int         len;
  } vec_t;

  vec_t tbl [7];
  logic [9:0] sbq [$];

  always #5 i_Pclk = ~i_Pclk;

  txframer #(
    .DATA_W(DW),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS(SB)
  ) dut (
    .i_Pclk  (i_Pclk),
    .i_Rst   (i_Rst),
    .i_Valid (i_Valid),
    .i_Data  (i_Data),
    .i_Parity(i_Parity),
`ifdef TXFRAMER_BREAK_EN
    .i_Break (i_Break),
`endif
    .o_Ready (o_Ready),
    .o_Tx    (o_Tx),
    .o_Busy  (o_Busy),
    .o_Done  (o_Done)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int nbits(input logic [1:0] m);
    return 1 + DW + ((m != PAR_NONE) ? 1 : 0) + SB;
  endfunction

  function automatic logic par_of(input logic [7:0] d, input logic [1:0] m);
    int ones;
    ones = $countones(d);
    if (m == PAR_EVEN) return (ones % 2) == 1;
    if (m == PAR_ODD)  return (ones % 2) == 0;
    return 1'b1;
  endfunction

  function automatic logic fbit(input logic [7:0] d, input logic [1:0] m,
                                input int k);
    if (k == 0) return 1'b0;
    if (k <= DW) return d[k-1];
    if (k == DW + 1 && m != PAR_NONE) return par_of(d, m);
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] d, input logic [1:0] m);
    int n;
    n = 0;
    i_Valid  = 1'b1;
    i_Data   = d;
    i_Parity = m;
    while (o_Ready !== 1'b1 && n < 3000) begin
      @(negedge i_Pclk);
      n++;
    end
    if (n >= 3000) check("push_timeout", 0, 1);
    @(posedge i_Pclk);
    #1;
    i_Valid = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      @(negedge i_Pclk);
      n++;
    end while (o_Tx !== 1'b0 && n < 3000);
    if (o_Tx !== 1'b0) check("start_timeout", 0, 1);
  endtask

  // Called on the first start-bit cycle; walks the whole frame.
  task automatic check_frame(input string name, input logic [7:0] d,
                             input logic [1:0] m);
    int total;
    int bad;
    int bdone;
    total = nbits(m) * CPB;
    bad   = 0;
    bdone = 0;
    nbusy = 0;
    for (int c = 0; c < total; c++) begin
      if (c > 0) @(negedge i_Pclk);
      samp[c] = o_Tx;
      if (o_Tx !== fbit(d, m, c / CPB)) bad++;
      if (o_Done !== (c == total - 1)) bdone++;
      if (o_Busy === 1'b1) nbusy++;
    end
    check({name, "_bits"}, bad, 0);
    check({name, "_done"}, bdone, 0);
  endtask

  task automatic check_idle(input string name);
    @(negedge i_Pclk);
    check({name, "_idle_busy"}, o_Busy, 0);
    check({name, "_idle_tx"}, o_Tx, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nb1;
    tbl[0] = '{8'h55, PAR_EVEN, 1'b0, 44};
    tbl[1] = '{8'h03, PAR_ODD,  1'b1, 44};
    tbl[2] = '{8'h03, PAR_MARK, 1'b1, 44};
    tbl[3] = '{8'h03, PAR_EVEN, 1'b0, 44};
    tbl[4] = '{8'hA5, PAR_NONE, 1'b1, 40};
    tbl[5] = '{8'hFF, PAR_ODD,  1'b1, 44};
    tbl[6] = '{8'h80, PAR_EVEN, 1'b1, 44};

    i_Rst    = 1'b1;
    i_Valid  = 1'b0;
    i_Data   = '0;
    i_Parity = PAR_NONE;
`ifdef TXFRAMER_BREAK_EN
    i_Break  = 1'b0;
`endif
    repeat (3) @(negedge i_Pclk);
    check("rst_tx", o_Tx, 1);
    check("rst_ready", o_Ready, 1);
    check("rst_busy", o_Busy, 0);
    check("rst_done", o_Done, 0);
    i_Rst = 1'b0;
    repeat (2) @(negedge i_Pclk);
    check("post_rst_tx", o_Tx, 1);
    check("post_rst_ready", o_Ready, 1);

    for (int i = 0; i < 7; i++) begin
      push(tbl[i].d, tbl[i].m);
      wait_start(n);
      check("vec_lat", n, 2);
      check_frame("vec", tbl[i].d, tbl[i].m);
      check("vec_len", nbusy, tbl[i].len);
      check("vec_par", samp[9 * CPB + 1], tbl[i].par);
      check_idle("vec");
      check("vec_ready", o_Ready, 1);
    end

    fork
      begin
        push(8'h11, PAR_EVEN);
        push(8'h22, PAR_EVEN);
        @(negedge i_Pclk);
        check("b2b_ready_low", o_Ready, 0);
      end
      begin
        int m;
        wait_start(m);
        check("b2b_lat", m, 2);
        check_frame("b2b1", 8'h11, PAR_EVEN);
        nb1 = nbusy;
        wait_start(m);
        check("b2b_gap", m, 1);
        check_frame("b2b2", 8'h22, PAR_EVEN);
        check("b2b_busy", nb1 + nbusy, 88);
      end
    join
    check_idle("b2b");
    check("b2b_ready_back", o_Ready, 1);

    push(8'h5A, PAR_EVEN);
    wait_start(n);
    repeat (13) @(negedge i_Pclk);
    push(8'h77, PAR_ODD);
    check("pre_rst_tx", o_Tx, 0);
    check("pre_rst_busy", o_Busy, 1);
    i_Rst = 1'b1;
    #1;
    check("mid_rst_tx", o_Tx, 1);
    check("mid_rst_busy", o_Busy, 0);
    check("mid_rst_ready", o_Ready, 1);
    @(negedge i_Pclk);
    i_Rst = 1'b0;
    repeat (20) @(negedge i_Pclk);
    check("rst_discard_busy", o_Busy, 0);
    check("rst_discard_tx", o_Tx, 1);
    push(8'hC3, PAR_ODD);
    wait_start(n);
    check("after_rst_lat", n, 2);
    check_frame("after_rst", 8'hC3, PAR_ODD);
    check_idle("after_rst");

    fork
      begin
        logic [7:0] d;
        logic [1:0] m;
        for (int i = 0; i < 40; i++) begin
          d = 8'($urandom);
          m = 2'($urandom_range(0, 3));
          push(d, m);
          sbq.push_back({m, d});
          if ($urandom_range(0, 2) != 0)
            repeat ($urandom_range(1, 60)) @(negedge i_Pclk);
        end
      end
      begin
        int k;
        logic [9:0] e;
        for (int f = 0; f < 40; f++) begin
          wait_start(k);
          if (sbq.size() == 0) begin
            check("rnd_unexpected_frame", 0, 1);
          end else begin
            e = sbq.pop_front();
            check_frame("rnd", e[7:0], e[9:8]);
          end
        end
      end
    join
    check("rnd_sb_empty", sbq.size(), 0);
    check_idle("rnd");

`ifdef TXFRAMER_BREAK_EN
    begin
      int lows;
      i_Break  = 1'b1;
      i_Valid  = 1'b1;
      i_Data   = 8'h3C;
      i_Parity = PAR_NONE;
      @(posedge i_Pclk);
      #1;
      i_Valid = 1'b0;
      lows = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge i_Pclk);
        if (o_Tx === 1'b0) lows++;
        if (i == 0) check("brk_ready", o_Ready, 0);
        if (i == 0) check("brk_busy", o_Busy, 0);
      end
      i_Break = 1'b0;
      check("brk_low", lows, 20);
      wait_start(n);
      check("brk_mark", (n - 1) >= CPB, 1);
      check_frame("brk", 8'h3C, PAR_NONE);
      check_idle("brk");
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
